// File: rtl/axil_trk_pkg.sv
// Shared types and constants for the AXI4-Lite transaction tracker.
// Holds FSM states, violation bit indices and counter widths.
package axil_trk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HUNG   = 2'd2
   } trk_state_e;

   localparam int CNT_W   = 32;
   localparam int ERR_W   = 16;
   localparam int OUTST_W = 4;
   localparam int WD_W    = 16;
   localparam int VIOL_W  = 7;

   localparam int V_AW_DROP = 0;
   localparam int V_W_DROP  = 1;
   localparam int V_AR_DROP = 2;
   localparam int V_ORPH_B  = 3;
   localparam int V_ORPH_R  = 4;
   localparam int V_WR_OVF  = 5;
   localparam int V_RD_OVF  = 6;

endpackage

// File: rtl/axil_trk_port.sv
// Per-link passive monitor: outstanding depth, counters,
// protocol violation flags and a watchdog FSM.
module axil_trk_port
   import axil_trk_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYC     = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               awvalid,
   input  logic               awready,
   input  logic               wvalid,
   input  logic               wready,
   input  logic               bvalid,
   input  logic               bready,
   input  logic [1:0]         bresp,
   input  logic               arvalid,
   input  logic               arready,
   input  logic               rvalid,
   input  logic               rready,
   input  logic [1:0]         rresp,
   output logic [CNT_W-1:0]   wr_cnt,
   output logic [CNT_W-1:0]   rd_cnt,
   output logic [ERR_W-1:0]   err_cnt,
   output logic [OUTST_W-1:0] wr_outst,
   output logic [OUTST_W-1:0] rd_outst,
   output logic [VIOL_W-1:0]  viol,
   output logic               timeout,
   output logic [1:0]         state
);

   localparam logic [OUTST_W-1:0] MAX_O   = OUTST_W'(MAX_OUTSTANDING);
   localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic aw_hs, b_hs, ar_hs, r_hs, resp_hs;
   logic aw_pend_q, w_pend_q, ar_pend_q;
   logic [OUTST_W-1:0] wr_outst_q, wr_outst_d;
   logic [OUTST_W-1:0] rd_outst_q, rd_outst_d;
   logic [CNT_W-1:0]   wr_cnt_q, rd_cnt_q;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [ERR_W:0]     err_sum;
   logic [1:0]         err_inc;
   logic [VIOL_W-1:0]  viol_q, viol_ev;
   logic [WD_W-1:0]    wdog_q;
   logic               timeout_q;
   logic               busy_d;
   trk_state_e         state_q;

   assign aw_hs   = awvalid & awready;
   assign b_hs    = bvalid & bready;
   assign ar_hs   = arvalid & arready;
   assign r_hs    = rvalid & rready;
   assign resp_hs = b_hs | r_hs;

   // Next outstanding depths and this cycle's violation events
   always_comb begin
      wr_outst_d = wr_outst_q;
      rd_outst_d = rd_outst_q;
      viol_ev    = '0;
      if (aw_hs && !b_hs) begin
         if (wr_outst_q == MAX_O) viol_ev[V_WR_OVF] = 1'b1;
         else wr_outst_d = wr_outst_q + OUTST_W'(1);
      end else if (b_hs && !aw_hs) begin
         if (wr_outst_q == '0) viol_ev[V_ORPH_B] = 1'b1;
         else wr_outst_d = wr_outst_q - OUTST_W'(1);
      end
      if (ar_hs && !r_hs) begin
         if (rd_outst_q == MAX_O) viol_ev[V_RD_OVF] = 1'b1;
         else rd_outst_d = rd_outst_q + OUTST_W'(1);
      end else if (r_hs && !ar_hs) begin
         if (rd_outst_q == '0) viol_ev[V_ORPH_R] = 1'b1;
         else rd_outst_d = rd_outst_q - OUTST_W'(1);
      end
      viol_ev[V_AW_DROP] = aw_pend_q & ~awvalid;
      viol_ev[V_W_DROP]  = w_pend_q & ~wvalid;
      viol_ev[V_AR_DROP] = ar_pend_q & ~arvalid;
   end

   // Saturating error accumulation, up to two errors per cycle
   always_comb begin
      err_inc = {1'b0, b_hs && (bresp != 2'b00)}
              + {1'b0, r_hs && (rresp != 2'b00)};
      err_sum = {1'b0, err_q} + (ERR_W+1)'(err_inc);
      err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
   end

   assign busy_d = (wr_outst_d != '0) || (rd_outst_d != '0);

   // Counters, depths, sticky flags and valid-stall history
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_pend_q  <= 1'b0;
         w_pend_q   <= 1'b0;
         ar_pend_q  <= 1'b0;
         wr_outst_q <= '0;
         rd_outst_q <= '0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         err_q      <= '0;
         viol_q     <= '0;
      end else begin
         aw_pend_q <= awvalid & ~awready;
         w_pend_q  <= wvalid & ~wready;
         ar_pend_q <= arvalid & ~arready;
         if (clear) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= '0;
            viol_q   <= '0;
         end else begin
            wr_outst_q <= wr_outst_d;
            rd_outst_q <= rd_outst_d;
            if (b_hs && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            if (r_hs && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            err_q  <= err_d;
            viol_q <= viol_q | viol_ev;
         end
      end
   end

   // Link state FSM with watchdog and sticky timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else if (clear) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               wdog_q <= '0;
               if (busy_d) state_q <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (resp_hs) begin
                  wdog_q <= '0;
                  if (!busy_d) state_q <= ST_IDLE;
               end else if (wdog_q == WD_LAST) begin
                  wdog_q    <= '0;
                  timeout_q <= 1'b1;
                  state_q   <= ST_HUNG;
               end else begin
                  wdog_q <= wdog_q + WD_W'(1);
               end
            end
            ST_HUNG: begin
               wdog_q <= '0;
               if (resp_hs) state_q <= busy_d ? ST_ACTIVE : ST_IDLE;
            end
            default: begin
               wdog_q  <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign wr_cnt   = wr_cnt_q;
   assign rd_cnt   = rd_cnt_q;
   assign err_cnt  = err_q;
   assign wr_outst = wr_outst_q;
   assign rd_outst = rd_outst_q;
   assign viol     = viol_q;
   assign timeout  = timeout_q;
   assign state    = state_q;

endmodule

// File: rtl/axil_txn_tracker.sv
// Multi-link AXI4-Lite transaction tracker: one passive
// per-port monitor per observed link, buses sliced by port.
module axil_txn_tracker
   import axil_trk_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYC     = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic [NUM_PORTS-1:0]         awvalid,
   input  logic [NUM_PORTS-1:0]         awready,
   input  logic [NUM_PORTS-1:0]         wvalid,
   input  logic [NUM_PORTS-1:0]         wready,
   input  logic [NUM_PORTS-1:0]         bvalid,
   input  logic [NUM_PORTS-1:0]         bready,
   input  logic [NUM_PORTS-1:0]         arvalid,
   input  logic [NUM_PORTS-1:0]         arready,
   input  logic [NUM_PORTS-1:0]         rvalid,
   input  logic [NUM_PORTS-1:0]         rready,
   input  logic [2*NUM_PORTS-1:0]       bresp,
   input  logic [2*NUM_PORTS-1:0]       rresp,
   output logic [CNT_W*NUM_PORTS-1:0]   wr_cnt,
   output logic [CNT_W*NUM_PORTS-1:0]   rd_cnt,
   output logic [ERR_W*NUM_PORTS-1:0]   err_cnt,
   output logic [OUTST_W*NUM_PORTS-1:0] wr_outst,
   output logic [OUTST_W*NUM_PORTS-1:0] rd_outst,
   output logic [VIOL_W*NUM_PORTS-1:0]  viol,
   output logic [NUM_PORTS-1:0]         timeout,
   output logic [2*NUM_PORTS-1:0]       state
);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      axil_trk_port #(
         .MAX_OUTSTANDING(MAX_OUTSTANDING),
         .TIMEOUT_CYC    (TIMEOUT_CYC)
      ) u_port (
         .clk     (clk),
         .rst     (rst),
         .clear   (clear),
         .awvalid (awvalid[p]),
         .awready (awready[p]),
         .wvalid  (wvalid[p]),
         .wready  (wready[p]),
         .bvalid  (bvalid[p]),
         .bready  (bready[p]),
         .bresp   (bresp[2*p +: 2]),
         .arvalid (arvalid[p]),
         .arready (arready[p]),
         .rvalid  (rvalid[p]),
         .rready  (rready[p]),
         .rresp   (rresp[2*p +: 2]),
         .wr_cnt  (wr_cnt[CNT_W*p +: CNT_W]),
         .rd_cnt  (rd_cnt[CNT_W*p +: CNT_W]),
         .err_cnt (err_cnt[ERR_W*p +: ERR_W]),
         .wr_outst(wr_outst[OUTST_W*p +: OUTST_W]),
         .rd_outst(rd_outst[OUTST_W*p +: OUTST_W]),
         .viol    (viol[VIOL_W*p +: VIOL_W]),
         .timeout (timeout[p]),
         .state   (state[2*p +: 2])
      );
   end

endmodule

// File: doc/axil_txn_tracker.md
AXIL_TXN_TRACKER -- requirements
Module: axil_txn_tracker

Interface
REQ-001 The block SHALL take parameter NUM_PORTS, default 2, meaning the number of independent AXI4-Lite links observed (legal range 1..8).
REQ-002 The block SHALL take parameter MAX_OUTSTANDING, default 4, meaning the legal outstanding depth per direction per port (legal range 1..15).
REQ-003 The block SHALL take parameter TIMEOUT_CYC, default 1024, meaning the watchdog limit in clk cycles (legal range 2..65535).
REQ-004 Port clk SHALL be an input of width 1: the single clock; all ports are sampled on its rising edge.
REQ-005 Port rst SHALL be an input of width 1: synchronous, active-high reset.
REQ-006 Port clear SHALL be an input of width 1: a synchronous one-cycle pulse that zeroes all counters and sticky flags.
REQ-007 Ports awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid and rready SHALL be inputs of width NUM_PORTS each: observed handshake signals, bit p belonging to port p.
REQ-008 Ports bresp and rresp SHALL be inputs of width 2*NUM_PORTS each: observed response codes, slice p belonging to port p.
REQ-009 Ports wr_cnt and rd_cnt SHALL be outputs of width 32*NUM_PORTS each: completed write and read transaction counts per port.
REQ-010 Port err_cnt SHALL be an output of width 16*NUM_PORTS: the per-port count of responses with resp != 0.
REQ-011 Ports wr_outst and rd_outst SHALL be outputs of width 4*NUM_PORTS each: the current outstanding depth per port.
REQ-012 Port viol SHALL be an output of width 7*NUM_PORTS holding sticky per-port violation bits: [0] AW valid drop, [1] W valid drop, [2] AR valid drop, [3] orphan B, [4] orphan R, [5] write overflow, [6] read overflow.
REQ-013 Port timeout SHALL be an output of width NUM_PORTS: a sticky per-port watchdog flag.
REQ-014 Port state SHALL be an output of width 2*NUM_PORTS: the per-port FSM state (IDLE=0, ACTIVE=1, HUNG=2).

Function
REQ-015 A handshake on any channel SHALL be defined as valid and ready both high in the same cycle; the block is purely passive and SHALL drive nothing onto the observed links.
REQ-016 wr_outst SHALL increment on an AW handshake and decrement on a B handshake, and SHALL remain unchanged when both occur in the same cycle.
REQ-017 rd_outst SHALL follow the same rule, using AR handshakes to increment and R handshakes to decrement.
REQ-018 A B handshake while wr_outst=0 (with no AW handshake in the same cycle) SHALL set viol[3] and leave wr_outst at 0; orphan R SHALL set viol[4] in the same way.
REQ-019 An AW handshake while wr_outst=MAX_OUTSTANDING (with no B handshake in the same cycle) SHALL set viol[5] and saturate wr_outst; the read side SHALL set viol[6] in the same way.
REQ-020 Valid drop SHALL be detected when valid was high and ready low in the previous cycle and valid is low in the current cycle; this applies to the AW, W and AR channels.
REQ-021 The wr_cnt and rd_cnt counters SHALL increment on B and R handshakes respectively and SHALL saturate at 0xFFFFFFFF.
REQ-022 err_cnt SHALL increment when a B or R handshake carries resp != 0, add 2 when both do so in the same cycle, and saturate at 0xFFFF.
REQ-023 The per-port watchdog SHALL count cycles while wr_outst+rd_outst>0 and no B or R handshake occurs, SHALL reload to 0 on any B or R handshake, and SHALL hold at 0 while the port is IDLE.
REQ-024 When the watchdog reaches TIMEOUT_CYC-1 the block SHALL set timeout[p] on the next edge and the FSM SHALL enter HUNG.
REQ-025 The per-port FSM SHALL follow these transitions:
  - IDLE -> ACTIVE when the total outstanding count becomes nonzero.
  - ACTIVE -> IDLE when the total outstanding count returns to 0.
  - ACTIVE -> HUNG on watchdog expiry.
  - HUNG -> ACTIVE or IDLE on a B or R handshake, chosen by the resulting outstanding count; timeout[p] SHALL remain set.
REQ-026 When clear is asserted, clear SHALL take priority over every same-cycle event: all counters, viol, timeout and watchdogs are zeroed and events in that cycle are discarded. Outstanding depth and FSM state SHALL be preserved.
REQ-027 All outputs SHALL be registered, with a latency of 1 cycle from the handshake edge to the updated output.
REQ-028 Ports SHALL be fully independent; no event on port p SHALL alter the state of port q.

Reset
REQ-029 While rst is high, all outputs SHALL be 0, the FSM SHALL be IDLE, and watchdog and previous-valid history SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL discard all outstanding tracking; the first B or R handshake after reset SHALL be flagged as an orphan.
REQ-031 rst SHALL take priority over clear.

Structure
REQ-032 A shared package axil_trk_pkg SHALL hold the FSM state enum, the viol bit index constants, and the counter widths (32, 16, 4).
REQ-033 The per-port logic SHALL be a sub-module axil_trk_port, instantiated NUM_PORTS times in a generate loop; the top level SHALL only slice buses.

Verification
REQ-034 With NUM_PORTS=2, three AW+W then three B handshakes on port 0 SHALL give wr_outst[0] peaking at 3, then wr_cnt[0]=3 and state[0]=IDLE; all port 1 outputs SHALL remain 0.
REQ-035 With a simultaneous AR and R handshake at rd_outst=2, rd_outst SHALL stay 2 and rd_cnt SHALL increment by 1.
REQ-036 A B handshake at wr_outst=0 SHALL set viol[3]=1 and leave wr_outst=0; a fifth AW at MAX_OUTSTANDING=4 SHALL set viol[5]=1 and hold wr_outst=4.
REQ-037 With awvalid high and awready low for one cycle, then awvalid low, viol[0] SHALL be set one cycle later.
REQ-038 With TIMEOUT_CYC=16, one AR and no R for 16 cycles SHALL give timeout=1 and state=HUNG; a later R with rresp=2 SHALL give state=IDLE, err_cnt=1 and timeout still 1.
REQ-039 A clear pulse coincident with a B handshake SHALL give wr_cnt=0 and viol=0 with wr_outst unchanged; rst asserted at wr_outst=2 SHALL zero all outputs.
